// File: rtl/multiport_reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multiport_reg_file                                         |
// | Description : NR-read / NW-write register file with optional hardwired   |
// |               zero entry, write-to-read bypass and registered read.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multiport_reg_file #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  parameter int REG_RD  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic             wr_conf
);

  logic [DW-1:0] r_regs [DEPTH];
  logic [DW-1:0] w_rval [NR];

  // Ports are visited in ascending order so the highest enabled port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && !(ZERO_R0 != 0 && waddr[k*AW +: AW] == '0)) begin
          r_regs[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
        end
      end
    end
  end

  // Read value: zero entry beats bypass, bypass beats stored value.
  always_comb begin
    for (int j = 0; j < NR; j++) begin
      w_rval[j] = r_regs[raddr[j*AW +: AW]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (we[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) begin
            w_rval[j] = wdata[k*DW +: DW];
          end
        end
      end
      if (ZERO_R0 != 0 && raddr[j*AW +: AW] == '0) begin
        w_rval[j] = '0;
      end
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    if (REG_RD != 0) begin : g_reg
      logic [DW-1:0] r_rdata;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata <= '0;
        end else if (re[j]) begin
          r_rdata <= w_rval[j];
        end
      end
      assign rdata[j*DW +: DW] = r_rdata;
    end else begin : g_comb
      assign rdata[j*DW +: DW] = w_rval[j];
    end
  end

  if (REG_RD == 0) begin : g_re_unused
    logic w_unused_re;
    assign w_unused_re = ^re;
  end

  if (NW >= 2) begin : g_conf
    logic w_conf;
    logic r_wr_conf;
    assign w_conf = we[0] && we[1] && (waddr[0 +: AW] == waddr[AW +: AW]) &&
                    !(ZERO_R0 != 0 && waddr[0 +: AW] == '0);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_conf <= 1'b0;
      end else begin
        r_wr_conf <= w_conf;
      end
    end
    assign wr_conf = r_wr_conf;
  end else begin : g_no_conf
    assign wr_conf = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_multiport_reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multiport_reg_file                                      |
// | Description : Scoreboard bench driving three register-file variants.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multiport_reg_file;

    logic        clk;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] a_rdata, b_rdata, c_rdata;
    logic        a_conf, b_conf, c_conf;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // A: zero entry, bypass, combinational read
    multiport_reg_file #(.DW(32), .DEPTH(32), .AW(5), .NR(2), .NW(2),
                         .ZERO_R0(1), .BYPASS(1), .REG_RD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(a_rdata), .wr_conf(a_conf));

    // B: zero entry, bypass, registered read
    multiport_reg_file #(.DW(32), .DEPTH(32), .AW(5), .NR(2), .NW(2),
                         .ZERO_R0(1), .BYPASS(1), .REG_RD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(b_rdata), .wr_conf(b_conf));

    // C: ordinary entry 0, no bypass, combinational read
    multiport_reg_file #(.DW(32), .DEPTH(32), .AW(5), .NR(2), .NW(2),
                         .ZERO_R0(0), .BYPASS(0), .REG_RD(0)) u_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(c_rdata), .wr_conf(c_conf));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int id);
        case (id)
            0: return a_rdata[31:0];
            1: return a_rdata[63:32];
            2: return {31'd0, a_conf};
            3: return b_rdata[31:0];
            4: return b_rdata[63:32];
            5: return {31'd0, b_conf};
            6: return c_rdata[31:0];
            7: return c_rdata[63:32];
            default: return {31'd0, c_conf};
        endcase
    endfunction

    function automatic string idname(input int id);
        case (id)
            0: return "A.rdata0";
            1: return "A.rdata1";
            2: return "A.wr_conf";
            3: return "B.rdata0";
            4: return "B.rdata1";
            5: return "B.wr_conf";
            6: return "C.rdata0";
            7: return "C.rdata1";
            default: return "C.wr_conf";
        endcase
    endfunction

    // Monitor: checks every expectation due in the current cycle, away from the edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = actual(sb[i].id);
                tests++;
                if (act !== sb[i].exp) begin
                    fails++;
                    $display("FAIL %s cycle %0d: got %h expected %h",
                             idname(sb[i].id), cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int c, input int id, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.id  = id;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic conf_all(input int c, input logic a, input logic b, input logic cc);
        push(c, 2, {31'd0, a});
        push(c, 5, {31'd0, b});
        push(c, 8, {31'd0, cc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        re = '0;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        we[k] = 1'b1;
        waddr[k*5 +: 5] = a;
        wdata[k*32 +: 32] = d;
    endtask

    task automatic rd(input int j, input logic [4:0] a);
        raddr[j*5 +: 5] = a;
    endtask

    initial begin
        rst_n = 1'b0;
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        repeat (2) step();
        rst_n = 1'b1;

        // Reset asserted mid-cycle while writes are pending
        step();
        wr(0, 5'd4, 32'h55); wr(1, 5'd6, 32'h66);
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(); rd(0, 5'd4); rd(1, 5'd6); re = 2'b11;
        push(cyc, 0, 0); push(cyc, 1, 0); push(cyc, 6, 0); push(cyc, 7, 0);
        push(cyc, 3, 0); push(cyc, 4, 0);
        conf_all(cyc, 1'b0, 1'b0, 1'b0);
        push(cyc + 1, 3, 0); push(cyc + 1, 4, 0);

        // Basic write then read
        step();
        idle(); wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd0); rd(1, 5'd0);
        step();
        idle(); rd(0, 5'd5); re = 2'b01;
        push(cyc, 0, 32'hDEADBEEF); push(cyc, 6, 32'hDEADBEEF);
        push(cyc + 1, 3, 32'hDEADBEEF);

        // Write to entry 0
        step();
        idle(); wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0); re = 2'b01;
        push(cyc, 0, 0); push(cyc, 6, 0); push(cyc + 1, 3, 0);
        step();
        idle(); rd(0, 5'd0); re = 2'b01;
        push(cyc, 0, 0); push(cyc, 6, 32'hFFFFFFFF); push(cyc + 1, 3, 0);

        // Bypass versus old value
        step();
        idle(); wr(0, 5'd7, 32'd1);
        step();
        idle(); wr(0, 5'd7, 32'd2); rd(1, 5'd7); re = 2'b10;
        push(cyc, 1, 32'd2); push(cyc, 7, 32'd1); push(cyc + 1, 4, 32'd2);
        step();
        idle(); rd(1, 5'd7); re = 2'b10;
        push(cyc, 1, 32'd2); push(cyc, 7, 32'd2); push(cyc + 1, 4, 32'd2);

        // Write conflict at an ordinary address
        step();
        idle(); wr(0, 5'd9, 32'hA); wr(1, 5'd9, 32'hB); rd(0, 5'd9);
        push(cyc, 0, 32'hB); push(cyc, 6, 32'h0);
        conf_all(cyc, 1'b0, 1'b0, 1'b0);
        step();
        idle(); rd(0, 5'd9); re = 2'b01;
        conf_all(cyc, 1'b1, 1'b1, 1'b1);
        push(cyc, 0, 32'hB); push(cyc, 6, 32'hB); push(cyc + 1, 3, 32'hB);

        // Write conflict at address 0
        step();
        idle(); wr(0, 5'd0, 32'hA); wr(1, 5'd0, 32'hB);
        conf_all(cyc, 1'b0, 1'b0, 1'b0);
        step();
        idle(); rd(0, 5'd0); re = 2'b01;
        conf_all(cyc, 1'b0, 1'b0, 1'b1);
        push(cyc, 0, 0); push(cyc, 6, 32'hB); push(cyc + 1, 3, 0);

        // Registered-read hold when re drops
        step();
        idle(); wr(0, 5'd3, 32'h1234); wr(1, 5'd10, 32'h77);
        step();
        idle(); rd(0, 5'd3); rd(1, 5'd10); re = 2'b11;
        push(cyc, 0, 32'h1234); push(cyc, 1, 32'h77);
        push(cyc, 6, 32'h1234); push(cyc, 7, 32'h77);
        conf_all(cyc, 1'b0, 1'b0, 1'b0);
        push(cyc + 1, 3, 32'h1234); push(cyc + 1, 4, 32'h77);
        step();
        idle(); rd(0, 5'd5); rd(1, 5'd7);
        push(cyc, 0, 32'hDEADBEEF); push(cyc, 1, 32'd2);
        push(cyc + 1, 3, 32'h1234); push(cyc + 1, 4, 32'h77);
        step();
        idle(); rd(0, 5'd9);
        push(cyc + 1, 3, 32'h1234);

        repeat (3) step();

        idle(); rd(0, 5'd5); rd(1, 5'd7);
        #1;
        tests++;
        if (a_rdata[31:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL final A.rdata0: got %h expected DEADBEEF", a_rdata[31:0]);
        end
        tests++;
        if (a_rdata[63:32] !== 32'd2) begin
            fails++;
            $display("FAIL final A.rdata1: got %h expected 2", a_rdata[63:32]);
        end
        tests++;
        if (c_rdata[31:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL final C.rdata0: got %h expected DEADBEEF", c_rdata[31:0]);
        end
        tests++;
        if (c_rdata[63:32] !== 32'd2) begin
            fails++;
            $display("FAIL final C.rdata1: got %h expected 2", c_rdata[63:32]);
        end
        rd(0, 5'd0);
        #1;
        tests++;
        if (a_rdata[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL final A.rdata0 entry0: got %h expected 0", a_rdata[31:0]);
        end
        tests++;
        if (c_rdata[31:0] !== 32'hB) begin
            fails++;
            $display("FAIL final C.rdata0 entry0: got %h expected B", c_rdata[31:0]);
        end

        foreach (sb[i]) begin
            tests++;
            fails++;
            $display("FAIL %s never checked: expected %h at cycle %0d",
                     idname(sb[i].id), sb[i].exp, sb[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
